// File: rtl/apb_resp_pkg.sv
// Shared definitions for the APB register responder.
// Holds the address-map constants, the transfer FSM state encoding and the
// address-decode helper used by apb_reg_responder.
package apb_resp_pkg;

  localparam logic [31:0] CORE_OFFSET      = 32'h0000_0000;
  localparam logic [31:0] PERIPH_ID_OFFSET = 32'h0000_0080;
  localparam int unsigned REG_STRIDE       = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // hit   : address maps to a register (RW bank or ID)
  // ro    : address is the read-only ID register
  // index : RW bank index when hit && !ro
  typedef struct packed {
    logic       hit;
    logic       ro;
    logic [4:0] index;
  } dec_t;

  // Full-width compare: any stray upper address bit makes the access unmapped.
  function automatic dec_t addr_decode(input logic [31:0] addr,
                                       input int unsigned num_regs);
    dec_t        d;
    logic [31:0] off;
    d   = '0;
    off = addr - CORE_OFFSET;
    if (addr == PERIPH_ID_OFFSET) begin
      d.hit = 1'b1;
      d.ro  = 1'b1;
    end else if ((off[1:0] == 2'b00) && (off < num_regs * REG_STRIDE)) begin
      d.hit   = 1'b1;
      d.index = 5'(off >> 2);
    end
    return d;
  endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state counter for the APB access phase.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   i_clr        : force the count back to zero
//   i_en         : advance the count by one
//   o_tc         : count has reached WAIT_CYCLES (transfer may complete)
module apb_wait_cnt #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_tc = (r_cnt == 4'(WAIT_CYCLES));

endmodule

// File: rtl/apb_reg_responder.sv
// APB3 completer for peripheral configuration registers.
// Register 0 is the clock-gate enable word, registers 1..NUM_REGS-1 are
// general RW storage, and offset 0x80 returns the read-only ID_VALUE.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   paddr_i .. penable_i  : APB request signals from the master
//   prdata_o, pready_o,
//   pslverr_o             : combinational APB response (only in completion cycle)
//   cg_en_o               : register 0 contents
//   regs_o                : flat view of all registers, reg i at [32*i +: 32]
module apb_reg_responder
  import apb_resp_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter logic [31:0] ID_VALUE    = 32'h0000_A5B1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_WIDTH-1:0]    paddr_i,
  input  logic [31:0]              pwdata_i,
  input  logic                     pwrite_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  output logic [31:0]              prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  output logic [31:0]              cg_en_o,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_ready;
  logic                    w_tc;
  logic                    w_cnt_clr;
  logic                    w_cnt_en;
  logic                    w_wr_en;
  dec_t                    w_dec;
  logic [31:0]             w_rd_reg;
  logic [NUM_REGS*32-1:0]  r_regs;

  assign w_dec = addr_decode(32'(paddr_i), NUM_REGS);

  // The counter only runs inside ACCESS; any other state parks it at zero so
  // every entry into ACCESS starts a fresh wait sequence.
  assign w_cnt_clr = (r_state != ACCESS);
  assign w_cnt_en  = (r_state == ACCESS) && psel_i && penable_i && !w_tc;

  apb_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        // penable_i is ignored here so a master that skips setup still works.
        if (psel_i) w_next = ACCESS;
      end
      ACCESS: begin
        if (!psel_i) begin
          w_next = IDLE;
        end else if (penable_i && w_tc) begin
          w_ready = 1'b1;
          w_next  = DONE;
        end
      end
      DONE: begin
        // psel held with penable low is the setup of a back-to-back transfer.
        if (psel_i && !penable_i) w_next = ACCESS;
        else                      w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rd_reg = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (w_dec.index == 5'(i)) w_rd_reg = r_regs[32*i +: 32];
    end
  end

  assign w_wr_en   = w_ready && pwrite_i && w_dec.hit && !w_dec.ro;
  assign pready_o  = w_ready;
  assign pslverr_o = w_ready && (!w_dec.hit || (pwrite_i && w_dec.ro));
  assign prdata_o  = (w_ready && !pwrite_i && w_dec.hit) ?
                     (w_dec.ro ? ID_VALUE : w_rd_reg) : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_regs <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (w_dec.index == 5'(i)) r_regs[32*i +: 32] <= pwdata_i;
      end
    end
  end

  assign cg_en_o = r_regs[31:0];
  assign regs_o  = r_regs;

endmodule

// File: tb/tb_apb_reg_responder.sv
// Self-checking bench for apb_reg_responder: three instances with
// WAIT_CYCLES = 0, 1 and 3, checked against an address-map reference model.
module tb_apb_reg_responder;

  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'h0000_A5B1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             rst     [3];
  logic [11:0]      paddr   [3];
  logic [31:0]      pwdata  [3];
  logic             pwrite  [3];
  logic             psel    [3];
  logic             penable [3];
  logic [31:0]      prdata  [3];
  logic             pready  [3];
  logic             pslverr [3];
  logic [31:0]      cg_en   [3];
  logic [NR*32-1:0] regs    [3];

  logic [31:0] mreg [3][NR];
  int n_checks = 0;
  int n_pass   = 0;

  apb_reg_responder #(.NUM_REGS(NR), .WAIT_CYCLES(0), .ADDR_WIDTH(12), .ID_VALUE(ID)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .pwrite_i(pwrite[0]),
    .psel_i(psel[0]), .penable_i(penable[0]), .prdata_o(prdata[0]), .pready_o(pready[0]),
    .pslverr_o(pslverr[0]), .cg_en_o(cg_en[0]), .regs_o(regs[0]));
  apb_reg_responder #(.NUM_REGS(NR), .WAIT_CYCLES(1), .ADDR_WIDTH(12), .ID_VALUE(ID)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .pwrite_i(pwrite[1]),
    .psel_i(psel[1]), .penable_i(penable[1]), .prdata_o(prdata[1]), .pready_o(pready[1]),
    .pslverr_o(pslverr[1]), .cg_en_o(cg_en[1]), .regs_o(regs[1]));
  apb_reg_responder #(.NUM_REGS(NR), .WAIT_CYCLES(3), .ADDR_WIDTH(12), .ID_VALUE(ID)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .paddr_i(paddr[2]), .pwdata_i(pwdata[2]), .pwrite_i(pwrite[2]),
    .psel_i(psel[2]), .penable_i(penable[2]), .prdata_o(prdata[2]), .pready_o(pready[2]),
    .pslverr_o(pslverr[2]), .cg_en_o(cg_en[2]), .regs_o(regs[2]));

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [NR*32-1:0] flat(input int d);
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = mreg[d][i];
    return v;
  endfunction

  // Reference: 0x80 is ID (read-only), word-aligned offsets below 4*NR are
  // registers, everything else is an error. Writes update the model.
  function automatic void model(input int d, input bit wr, input logic [11:0] a,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err);
    int unsigned ai;
    ai  = a;
    rd  = 32'h0;
    err = 1'b0;
    if (ai == 32'h80) begin
      if (wr) err = 1'b1;
      else    rd  = ID;
    end else if ((ai % 4 == 0) && (ai / 4 < NR)) begin
      if (wr) mreg[d][ai/4] = wd;
      else    rd = mreg[d][ai/4];
    end else begin
      err = 1'b1;
    end
  endfunction

  function automatic void model_reset(input int d);
    for (int i = 0; i < NR; i++) mreg[d][i] = 32'h0;
  endfunction

  // One complete APB transfer with a setup cycle; lat counts access cycles
  // before pready, to flags an expired cycle budget.
  task automatic apb_xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat, output bit to);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 0; to = 1'b1; rd = 32'h0; err = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pready[d] === 1'b1) begin
        rd = prdata[d]; err = pslverr[d]; to = 1'b0;
        break;
      end
      lat++;
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic err; int lat; bit to;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; model_reset(d);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++; if ({pready[d], pslverr[d], prdata[d]} !== 34'h0)
        $display("FAIL reset_resp[%0d]: got %b/%b/%h want 0/0/0", d, pready[d], pslverr[d], prdata[d]); else n_pass++;
      n_checks++; if (regs[d] !== '0 || cg_en[d] !== 32'h0)
        $display("FAIL reset_regs[%0d]: got cg %h regs %h want 0", d, cg_en[d], regs[d]); else n_pass++;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    apb_xfer(1, 1'b0, 12'h000, 32'h0, rd, err, lat, to);
    n_checks++; if (to || rd !== 32'h0 || err !== 1'b0)
      $display("FAIL reset_rd_cg: got %h err %b to %0d want 00000000 err 0", rd, err, to); else n_pass++;
    apb_xfer(1, 1'b0, 12'h080, 32'h0, rd, err, lat, to);
    n_checks++; if (to || rd !== ID || err !== 1'b0)
      $display("FAIL reset_rd_id: got %h err %b want %h err 0", rd, err, ID); else n_pass++;
    n_checks++; if (cg_en[1] !== 32'h0)
      $display("FAIL reset_cg_en: got %h want 0", cg_en[1]); else n_pass++;
  endtask

  task automatic test_write_cg;
    logic [31:0] rd, erd; logic err, eerr; int lat; bit to;
    model(1, 1'b1, 12'h000, 32'h5, erd, eerr);
    apb_xfer(1, 1'b1, 12'h000, 32'h5, rd, err, lat, to);
    n_checks++; if (to || lat !== 1 || err !== 1'b0)
      $display("FAIL wr_cg_lat: got lat %0d err %b to %0d want lat 1 err 0", lat, err, to); else n_pass++;
    n_checks++; if (cg_en[1] !== 32'h5)
      $display("FAIL wr_cg_out: got %h want 00000005", cg_en[1]); else n_pass++;
    apb_xfer(1, 1'b0, 12'h000, 32'h0, rd, err, lat, to);
    n_checks++; if (rd !== 32'h5 || err !== 1'b0)
      $display("FAIL wr_cg_readback: got %h err %b want 00000005 err 0", rd, err); else n_pass++;
  endtask

  task automatic test_rmw;
    logic [31:0] rd, erd; logic err, eerr; int lat; bit to;
    apb_xfer(1, 1'b0, 12'h000, 32'h0, rd, err, lat, to);
    model(1, 1'b1, 12'h000, rd | 32'h8, erd, eerr);
    apb_xfer(1, 1'b1, 12'h000, rd | 32'h8, rd, err, lat, to);
    n_checks++; if (cg_en[1] !== 32'hD)
      $display("FAIL rmw_cg: got %h want 0000000d", cg_en[1]); else n_pass++;
  endtask

  task automatic test_errors;
    logic [31:0] rd, erd; logic err, eerr; int lat; bit to;
    logic [11:0] addrs [3];
    addrs[0] = 12'h080; addrs[1] = 12'h040; addrs[2] = 12'h006;
    for (int k = 0; k < 3; k++) begin
      model(1, 1'b1, addrs[k], 32'hDEAD_BEEF, erd, eerr);
      apb_xfer(1, 1'b1, addrs[k], 32'hDEAD_BEEF, rd, err, lat, to);
      n_checks++; if (to || err !== 1'b1)
        $display("FAIL err_wr_%h: got err %b to %0d want err 1", addrs[k], err, to); else n_pass++;
      n_checks++; if (regs[1] !== flat(1))
        $display("FAIL err_regs_%h: got %h want %h", addrs[k], regs[1], flat(1)); else n_pass++;
    end
    apb_xfer(1, 1'b0, 12'h080, 32'h0, rd, err, lat, to);
    n_checks++; if (rd !== ID || err !== 1'b0)
      $display("FAIL err_id_intact: got %h err %b want %h err 0", rd, err, ID); else n_pass++;
  endtask

  task automatic test_abort_and_reset;
    logic [31:0] rd, erd; logic err, eerr; int lat; bit to;
    model(2, 1'b1, 12'h008, 32'h1234_5678, erd, eerr);
    apb_xfer(2, 1'b1, 12'h008, 32'h1234_5678, rd, err, lat, to);
    n_checks++; if (to || lat !== 3)
      $display("FAIL wait3_lat: got %0d to %0d want 3", lat, to); else n_pass++;
    // Abort: psel dropped one access cycle in, before completion.
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 12'h008; pwdata[2] = 32'hFFFF_FFFF;
    @(posedge clk); #1; penable[2] = 1'b1;
    @(negedge clk);
    n_checks++; if (pready[2] !== 1'b0)
      $display("FAIL abort_early_ready: got %b want 0", pready[2]); else n_pass++;
    @(posedge clk); #1; psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge clk);
    n_checks++; if ({pready[2], pslverr[2], prdata[2]} !== 34'h0)
      $display("FAIL abort_resp: got %b/%b/%h want 0/0/0", pready[2], pslverr[2], prdata[2]); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (regs[2] !== flat(2))
      $display("FAIL abort_regs: got %h want %h", regs[2], flat(2)); else n_pass++;
    apb_xfer(2, 1'b0, 12'h008, 32'h0, rd, err, lat, to);
    n_checks++; if (to || rd !== 32'h1234_5678 || lat !== 3)
      $display("FAIL abort_readback: got %h lat %0d want 12345678 lat 3", rd, lat); else n_pass++;
    // Reset in the middle of a write.
    model(2, 1'b1, 12'h00C, 32'h0000_CAFE, erd, eerr);
    apb_xfer(2, 1'b1, 12'h00C, 32'h0000_CAFE, rd, err, lat, to);
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 12'h00C; pwdata[2] = 32'hFFFF_FFFF;
    @(posedge clk); #1; penable[2] = 1'b1;
    @(negedge clk); @(negedge clk);
    rst[2] = 1'b1;
    #1;
    model_reset(2);
    n_checks++; if ({pready[2], pslverr[2], prdata[2]} !== 34'h0)
      $display("FAIL rst_mid_resp: got %b/%b/%h want 0/0/0", pready[2], pslverr[2], prdata[2]); else n_pass++;
    n_checks++; if (regs[2] !== flat(2) || cg_en[2] !== 32'h0)
      $display("FAIL rst_mid_regs: got %h want %h", regs[2], flat(2)); else n_pass++;
    @(posedge clk); #1; psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge clk); rst[2] = 1'b0;
    apb_xfer(2, 1'b0, 12'h00C, 32'h0, rd, err, lat, to);
    n_checks++; if (to || rd !== 32'h0 || err !== 1'b0 || lat !== 3)
      $display("FAIL rst_mid_after: got %h err %b lat %0d want 0 err 0 lat 3", rd, err, lat); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] erd; logic eerr; int c1, c2; bit got1, got2;
    model(0, 1'b1, 12'h004, 32'h11, erd, eerr);
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 12'h004; pwdata[0] = 32'h11;
    @(posedge clk); #1; penable[0] = 1'b1;
    @(negedge clk);
    got1 = (pready[0] === 1'b1) && (pslverr[0] === 1'b0); c1 = cyc;
    n_checks++; if (!got1)
      $display("FAIL b2b_wr_ready: got ready %b err %b want 1/0", pready[0], pslverr[0]); else n_pass++;
    @(posedge clk); #1; penable[0] = 1'b0; pwrite[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (pready[0] !== 1'b0)
      $display("FAIL b2b_gap_ready: got %b want 0", pready[0]); else n_pass++;
    @(posedge clk); #1; penable[0] = 1'b1;
    @(negedge clk);
    got2 = (pready[0] === 1'b1); c2 = cyc;
    n_checks++; if (!got2 || prdata[0] !== 32'h11 || pslverr[0] !== 1'b0)
      $display("FAIL b2b_rd: got ready %b data %h want 1 00000011", pready[0], prdata[0]); else n_pass++;
    n_checks++; if (c2 - c1 !== 2)
      $display("FAIL b2b_spacing: got %0d want 2", c2 - c1); else n_pass++;
    @(posedge clk); #1; psel[0] = 1'b0; penable[0] = 1'b0;
    n_checks++; if (regs[0] !== flat(0))
      $display("FAIL b2b_regs: got %h want %h", regs[0], flat(0)); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, wd; logic err, eerr; int lat; bit to, wr;
    logic [11:0] a;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 30; n++) begin
        case ($urandom_range(0, 3))
          0:       a = 12'(4 * $urandom_range(0, NR - 1));
          1:       a = 12'h080;
          2:       a = 12'($urandom);
          default: a = 12'(4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3));
        endcase
        wr = 1'($urandom);
        wd = $urandom;
        model(d, wr, a, wd, erd, eerr);
        apb_xfer(d, wr, a, wd, rd, err, lat, to);
        n_checks++; if (to || lat !== wait_of(d))
          $display("FAIL rnd_lat[%0d] a=%h: got %0d to %0d want %0d", d, a, lat, to, wait_of(d)); else n_pass++;
        n_checks++; if (rd !== erd || err !== eerr)
          $display("FAIL rnd_resp[%0d] a=%h wr=%0d: got %h/%b want %h/%b", d, a, wr, rd, err, erd, eerr); else n_pass++;
        n_checks++; if (regs[d] !== flat(d) || cg_en[d] !== mreg[d][0])
          $display("FAIL rnd_regs[%0d] a=%h: got %h want %h", d, a, regs[d], flat(d)); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_cg();
    test_rmw();
    test_errors();
    test_abort_and_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
